// File: rtl/lsu.sv
// MEM-stage load/store unit: steers stores onto byte lanes, extracts and extends
// loads, flags misaligned accesses and bounds every dmem handshake with a timeout.
module lsu #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        exc_load_misaligned,
    output logic        exc_store_misaligned,
    output logic        exc_access_fault,
    output logic [31:0] exc_addr
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST =
        (ACK_TIMEOUT == 0) ? {CNT_W{1'b0}} : CNT_W'(ACK_TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       addr_q;
    logic [2:0]        f3_q;
    logic              done_q;
    logic              fault_q;

    logic              is_load;
    logic              is_store;
    logic              fn_ok;
    logic              aligned;
    logic              req_live;
    logic              start;
    logic              timeout;
    logic [3:0]        be_nxt;
    logic [31:0]       wdata_nxt;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic [31:0]       rdata_ext;

    // A simultaneous read+write request is resolved as a load.
    assign is_load  = mem_read;
    assign is_store = mem_write & ~mem_read;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fn_ok   = 1'b0;
        aligned = 1'b1;
        case (funct3)
            3'b000: fn_ok = 1'b1;
            3'b100: fn_ok = is_load;
            3'b001: begin
                fn_ok   = 1'b1;
                aligned = ~addr[0];
            end
            3'b101: begin
                fn_ok   = is_load;
                aligned = ~addr[0];
            end
            3'b010: begin
                fn_ok   = 1'b1;
                aligned = (addr[1:0] == 2'b00);
            end
            default: fn_ok = 1'b0;
        endcase
    end

    assign req_live = valid & (mem_read | mem_write) & ~flush & fn_ok & (state == IDLE);
    assign start    = req_live & aligned;

    assign exc_load_misaligned  = req_live & ~aligned & is_load;
    assign exc_store_misaligned = req_live & ~aligned & is_store;

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = wdata;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    be_nxt    = 4'b0001 << addr[1:0];
                    wdata_nxt = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_nxt = {2{wdata[15:0]}};
                end
                default: begin
                    be_nxt    = 4'b1111;
                    wdata_nxt = wdata;
                end
            endcase
        end
    end

    // Extraction uses the offset and width latched at accept, not the live inputs.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   rbyte = dmem_rdata[7:0];
            2'b01:   rbyte = dmem_rdata[15:8];
            2'b10:   rbyte = dmem_rdata[23:16];
            default: rbyte = dmem_rdata[31:24];
        endcase
        rhalf = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'b000:  rdata_ext = {{24{rbyte[7]}}, rbyte};
            3'b100:  rdata_ext = {24'b0, rbyte};
            3'b001:  rdata_ext = {{16{rhalf[15]}}, rhalf};
            3'b101:  rdata_ext = {16'b0, rhalf};
            default: rdata_ext = dmem_rdata;
        endcase
    end

    assign timeout = (ACK_TIMEOUT != 0) && (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (dmem_ack || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            be_q      <= 4'b0;
            wdata_q   <= 32'b0;
            addr_q    <= 32'b0;
            f3_q      <= 3'b0;
            load_data <= 32'b0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        we_q    <= is_store;
                        be_q    <= be_nxt;
                        wdata_q <= wdata_nxt;
                        addr_q  <= addr;
                        f3_q    <= funct3;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        done_q <= 1'b1;
                        if (!we_q) load_data <= rdata_ext;
                    end else if (timeout) begin
                        fault_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem_req         = (state == BUSY);
    assign dmem_we          = we_q;
    assign dmem_be          = be_q;
    assign dmem_wdata       = wdata_q;
    assign dmem_addr        = {addr_q[31:2], 2'b00};
    assign stall            = start | (state == BUSY);
    assign done             = done_q;
    assign exc_access_fault = fault_q;
    assign exc_addr         = fault_q ? addr_q : addr;

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit in the MEM stage, directly downstream of the EX-stage ALU.
- Takes the ALU result as the effective address, plus rs2 store data and funct3, from the EX/MEM register.
- Runs a handshake with data memory: byte-lane steering, byte enables, load extraction with sign/zero extension, misalignment exceptions, and an ack-timeout access fault.
- Raises stall to hold the pipeline while an access is in flight.

Parameters:
ACK_TIMEOUT, 16, cycles in BUSY without dmem_ack before an access fault; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy ACK_TIMEOUT < 2^CNT_W.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
valid  in  1  EX/MEM slot holds a live instruction
mem_read  in  1  load instruction
mem_write  in  1  store instruction
funct3  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  32  effective address (ALU C)
wdata  in  32  store data (rs2)
flush  in  1  trap-unit kill of current MEM instruction
dmem_req  out  1  memory request, held until ack
dmem_we  out  1  1 = write
dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_ack  in  1  memory completes request this cycle
dmem_rdata  in  32  read word, valid with dmem_ack
stall  out  1  hold IF..MEM stages
done  out  1  one-cycle completion pulse
load_data  out  32  extended load result, valid while done=1
exc_load_misaligned  out  1  combinational, IDLE only
exc_store_misaligned  out  1  combinational, IDLE only
exc_access_fault  out  1  one-cycle pulse on timeout
exc_addr  out  32  faulting address (mtval)

Behaviour:
- Reset (async, any state): state=IDLE, counter=0. dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr, done, load_data, exc_access_fault are all 0. A reset during BUSY drops the request immediately.
- start = valid & (mem_read|mem_write) & ~flush & supported funct3 & aligned & state==IDLE.
- If mem_read and mem_write are both high, the access is treated as a load.
- Unsupported funct3: no access, no exception (the decoder owns illegal-instruction detection).
- Alignment: H/HU/SH require addr[0]=0. W/SW require addr[1:0]=00. B is always aligned.
- Misaligned in IDLE with valid & ~flush: exc_*_misaligned=1 and exc_addr=addr, combinationally. No request, no stall.
- States:
  - IDLE: on start, latch we, be, wdata lanes, addr[1:0], funct3 and full address; go BUSY. dmem_req rises at that edge.
  - BUSY: dmem_req=1 and request fields stable. Counter increments each cycle without ack.
    - On dmem_ack: dmem_req falls at the next edge. For loads, capture the extended read data into load_data. Go DONE.
    - Else, if ACK_TIMEOUT!=0 and counter==ACK_TIMEOUT-1: drop dmem_req, pulse exc_access_fault with exc_addr=latched address, go DONE.
  - DONE: done=1 for exactly one cycle (suppressed on timeout). load_data holds the captured value. No new start is taken this cycle; go IDLE.
- stall = start | (state==BUSY). stall is low in DONE, so the pipeline advances at the DONE edge.
- Minimum latency with ack in the first BUSY cycle is 3 cycles (IDLE accept, BUSY, DONE), i.e. 2 stall cycles.
- Store steering:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{wdata[15:0]}}.
  - SW: be=1111.
  - Loads drive be=1111 and dmem_we=0.
- Load extraction: select byte/half by the latched offset, then sign-extend for B/H or zero-extend for BU/HU. W passes through.
- Flush:
  - In IDLE, flush blocks start and suppresses exceptions.
  - In BUSY, flush is ignored: a bus transaction is never abandoned. The trap unit defers interrupts until stall=0.
- exc_addr outside a fault cycle is don't-care but must be driven.

Test Plan:
- SB addr=0x1003, wdata=0x000000A5, ack on first BUSY cycle -> dmem_addr=0x1000, be=1000, dmem_wdata=0xA5A5A5A5, we=1, stall high 2 cycles, done pulses in cycle 3.
- LB addr=0x1002, rdata=0x12F45678 -> load_data=0xFFFFFFF4. LBU at the same address -> 0x000000F4.
- LH addr=0x1002, rdata=0x80017FFF -> load_data=0xFFFF8001. LHU -> 0x00008001. LW addr=0x1000 -> 0x80017FFF.
- LW addr=0x1001 and SH addr=0x2003 -> exc_load_misaligned / exc_store_misaligned=1, exc_addr=0x1001 / 0x2003, dmem_req never asserted, stall=0.
- ACK_TIMEOUT=4, load with no ack -> dmem_req high 4 cycles, exc_access_fault pulse, exc_addr=latched address, done stays 0, back to IDLE.
- rst asserted mid-BUSY with ack delayed 5 cycles -> dmem_req=0 immediately, state IDLE, stall=0. A subsequent SW addr=0x10 wdata=0xDEADBEEF completes normally with be=1111.
